// File: rtl/vc_pkg.sv
// Victim cache shared types: entry count, opcodes, FSM states, per-entry tag/state record.
// No logic; the tag field is sized to a ceiling and the module zero-extends its TAG_W tags into it.
// Imported by victim_cache_ctrl and vc_tag_match.
package vc_pkg;

    localparam int VC_ENTRIES   = 8;
    localparam int VC_IDX_W     = 3;
    // Ceiling for the stored tag; modules zero-extend their TAG_W tags into this field.
    localparam int VC_TAG_MAX_W = 64;

    typedef enum logic {
        VC_LOOKUP = 1'b0,
        VC_INSERT = 1'b1
    } vc_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_INSERT,
        S_WB
    } vc_state_t;

    typedef struct packed {
        logic                    valid;
        logic                    dirty;
        logic [VC_TAG_MAX_W-1:0] tag;
    } vc_entry_t;

    // One-hot to binary index; an all-zero vector maps to 0.
    function automatic logic [VC_IDX_W-1:0] vc_oh2idx(input logic [VC_ENTRIES-1:0] oh);
        logic [VC_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < VC_ENTRIES; i++) begin
            if (oh[i]) idx = idx | VC_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vc_tag_match.sv
// Parallel tag compare and lowest-free-slot pick over all victim cache entries.
// Purely combinational, zero latency; no flow control.
// Ports: entries_i (entry records), tag_i (extended request tag) -> hit_vec_o/any_hit_o, free_vec_o/any_free_o.
module vc_tag_match
    import vc_pkg::*;
(
    input  vc_entry_t [VC_ENTRIES-1:0] entries_i,
    input  logic [VC_TAG_MAX_W-1:0]    tag_i,
    output logic [VC_ENTRIES-1:0]      hit_vec_o,
    output logic                       any_hit_o,
    output logic [VC_ENTRIES-1:0]      free_vec_o,
    output logic                       any_free_o
);

    always_comb begin
        hit_vec_o  = '0;
        free_vec_o = '0;
        any_free_o = 1'b0;
        for (int i = 0; i < VC_ENTRIES; i++) begin
            // Tags are unique among valid entries, so this is one-hot or zero.
            hit_vec_o[i] = entries_i[i].valid && (entries_i[i].tag == tag_i);
            if (!entries_i[i].valid && !any_free_o) begin
                free_vec_o[i] = 1'b1;
                any_free_o    = 1'b1;
            end
        end
        any_hit_o = |hit_vec_o;
    end

endmodule

// File: rtl/victim_cache_ctrl.sv
// 8-entry fully-associative victim cache control/storage; drives the LRU tracker pulses.
// Lookup responds 1 cycle after accept; insert writes 1 cycle after accept, or at the writeback handshake for a dirty victim.
// req_ready only in IDLE; wb_valid held with stable tag/data until wb_ready; rsp has no backpressure.
// Ports: clk/reset (sync, active-high); req_* request in; rsp_* lookup response; wb_* dirty victim out;
//        lru_number one-hot oldest from tracker; lru_update/add_cache pulses to tracker.
// Option: VC_SWAP_EN defined -> a lookup hit invalidates the entry instead of refreshing its LRU position.
module victim_cache_ctrl
    import vc_pkg::*;
#(
    parameter int TAG_W  = 26,
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [DATA_W-1:0]     req_data,
    input  logic                  req_dirty,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_dirty,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [TAG_W-1:0]      wb_tag,
    output logic [DATA_W-1:0]     wb_data,
    input  logic [VC_ENTRIES-1:0] lru_number,
    output logic [VC_ENTRIES-1:0] lru_update,
    output logic                  add_cache
);

    vc_state_t                   state_q, state_d;
    vc_entry_t [VC_ENTRIES-1:0]  entries_q, entries_d;
    logic [DATA_W-1:0]           data_q [VC_ENTRIES];
    logic [VC_IDX_W-1:0]         victim_q, victim_d;
    // The accepted op is carried by the state the FSM enters.
    logic [TAG_W-1:0]            req_tag_q;
    logic [DATA_W-1:0]           req_data_q;
    logic                        req_dirty_q;

    logic                        data_we;
    logic [VC_IDX_W-1:0]         data_widx;
    logic [VC_TAG_MAX_W-1:0]     req_tag_ext;
    logic [VC_ENTRIES-1:0]       hit_vec, free_vec;
    logic                        any_hit, any_free;
    logic [VC_IDX_W-1:0]         hit_idx, free_idx, lru_idx;

    assign req_tag_ext = VC_TAG_MAX_W'(req_tag_q);
    assign hit_idx     = vc_oh2idx(hit_vec);
    assign free_idx    = vc_oh2idx(free_vec);
    assign lru_idx     = vc_oh2idx(lru_number);

    vc_tag_match u_tag_match (
        .entries_i  (entries_q),
        .tag_i      (req_tag_ext),
        .hit_vec_o  (hit_vec),
        .any_hit_o  (any_hit),
        .free_vec_o (free_vec),
        .any_free_o (any_free)
    );

    always_comb begin
        state_d    = state_q;
        entries_d  = entries_q;
        victim_d   = victim_q;
        data_we    = 1'b0;
        data_widx  = '0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_hit    = 1'b0;
        rsp_data   = '0;
        rsp_dirty  = 1'b0;
        wb_valid   = 1'b0;
        wb_tag     = '0;
        wb_data    = '0;
        lru_update = '0;
        add_cache  = 1'b0;
        // Outputs stay quiet while reset is held, whatever the state register holds.
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid)
                        state_d = (vc_op_t'(req_op) == VC_INSERT) ? S_INSERT : S_LOOKUP;
                end
                S_LOOKUP: begin
                    rsp_valid = 1'b1;
                    rsp_hit   = any_hit;
                    if (any_hit) begin
                        rsp_data  = data_q[hit_idx];
                        rsp_dirty = entries_q[hit_idx].dirty;
`ifdef VC_SWAP_EN
                        // Block swaps back to L1: free the slot, tracker untouched.
                        entries_d[hit_idx].valid = 1'b0;
                        entries_d[hit_idx].dirty = 1'b0;
`else
                        lru_update = hit_vec;
`endif
                    end
                    state_d = S_IDLE;
                end
                S_INSERT: begin
                    if (any_hit) begin
                        entries_d[hit_idx].dirty = entries_q[hit_idx].dirty | req_dirty_q;
                        data_we    = 1'b1;
                        data_widx  = hit_idx;
                        lru_update = hit_vec;
                        state_d    = S_IDLE;
                    end else if (any_free) begin
                        entries_d[free_idx] = '{valid: 1'b1, dirty: req_dirty_q, tag: req_tag_ext};
                        data_we    = 1'b1;
                        data_widx  = free_idx;
                        lru_update = free_vec;
                        state_d    = S_IDLE;
                    end else begin
                        victim_d = lru_idx;
                        if (!entries_q[lru_idx].dirty) begin
                            entries_d[lru_idx] = '{valid: 1'b1, dirty: req_dirty_q, tag: req_tag_ext};
                            data_we   = 1'b1;
                            data_widx = lru_idx;
                            add_cache = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    // Victim index was latched in INSERT; the tracker is not pulsed until the handshake.
                    wb_valid = 1'b1;
                    wb_tag   = entries_q[victim_q].tag[TAG_W-1:0];
                    wb_data  = data_q[victim_q];
                    if (wb_ready) begin
                        entries_d[victim_q] = '{valid: 1'b1, dirty: req_dirty_q, tag: req_tag_ext};
                        data_we   = 1'b1;
                        data_widx = victim_q;
                        add_cache = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            entries_q   <= '0;
            victim_q    <= '0;
            req_tag_q   <= '0;
            req_data_q  <= '0;
            req_dirty_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            entries_q <= entries_d;
            victim_q  <= victim_d;
            if (req_valid && req_ready) begin
                req_tag_q   <= req_tag;
                req_data_q  <= req_data;
                req_dirty_q <= req_dirty;
            end
        end
    end

    // Block data needs no reset: it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (data_we) data_q[data_widx] <= req_data_q;
    end

    a_lru_onehot: assert property (@(posedge clk) disable iff (reset)
        ((state_q == S_INSERT) || (state_q == S_WB)) |-> $onehot(lru_number));

endmodule

// File: tb/tb_victim_cache_ctrl.sv
module tb_victim_cache_ctrl;
    localparam int TW = 26;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_ready, req_op = 1'b0, req_dirty = 1'b0;
    logic [TW-1:0] req_tag = '0;
    logic [DW-1:0] req_data = '0;
    logic          rsp_valid, rsp_hit, rsp_dirty, wb_valid, add_cache;
    logic          wb_ready = 1'b0;
    logic [DW-1:0] rsp_data, wb_data;
    logic [TW-1:0] wb_tag;
    logic [7:0]    lru_number = 8'h01, lru_update;

    always #5 clk = ~clk;

    victim_cache_ctrl #(.TAG_W(TW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_tag(req_tag), .req_data(req_data), .req_dirty(req_dirty),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data), .rsp_dirty(rsp_dirty),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data),
        .lru_number(lru_number), .lru_update(lru_update), .add_cache(add_cache)
    );

    // Behavioural model: cache contents plus the tracker as an oldest-first list.
    logic          m_valid [8];
    logic          m_dirty [8];
    logic [TW-1:0] m_tag   [8];
    logic [DW-1:0] m_data  [8];
    int            order[$];

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    logic          exp_req_ready, exp_rsp_valid, exp_rsp_hit, exp_rsp_dirty, exp_wb_valid, exp_add_cache;
    logic [DW-1:0] exp_rsp_data, exp_wb_data;
    logic [TW-1:0] exp_wb_tag;
    logic [7:0]    exp_lru_update;

    int            add_cnt = 0;
    int            wbv_cnt = 0;
    logic [7:0]    obs_lru = '0;
    int            last_hit, last_idx;
    logic [TW-1:0] last_wb_tag;
    bit            rst_wb_done = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",  DW'(req_ready),  DW'(exp_req_ready));
            chk("rsp_valid",  DW'(rsp_valid),  DW'(exp_rsp_valid));
            chk("rsp_hit",    DW'(rsp_hit),    DW'(exp_rsp_hit));
            chk("rsp_data",   rsp_data,        exp_rsp_data);
            chk("rsp_dirty",  DW'(rsp_dirty),  DW'(exp_rsp_dirty));
            chk("wb_valid",   DW'(wb_valid),   DW'(exp_wb_valid));
            chk("wb_tag",     DW'(wb_tag),     DW'(exp_wb_tag));
            chk("wb_data",    wb_data,         exp_wb_data);
            chk("lru_update", DW'(lru_update), DW'(exp_lru_update));
            chk("add_cache",  DW'(add_cache),  DW'(exp_add_cache));
            if (add_cache === 1'b1) add_cnt++;
            if (wb_valid === 1'b1) wbv_cnt++;
            if (lru_update !== 8'h00) obs_lru = lru_update;
        end
    end

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int m_find(input logic [TW-1:0] t);
        for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < 8; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    task automatic touch(input int i);
        for (int p = 0; p < order.size(); p++) begin
            if (order[p] == i) begin
                order.delete(p);
                break;
            end
        end
        order.push_back(i);
    endtask

    task automatic m_put(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d, input logic dty);
        m_valid[i] = 1'b1;
        m_dirty[i] = dty;
        m_tag[i]   = t;
        m_data[i]  = d;
    endtask

    task automatic m_reset();
        order = {};
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
            order.push_back(i);
        end
    endtask

    // Start a cycle: random junk on inputs the DUT must ignore, all expectations quiet.
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        lru_number     = 8'h01 << order[0];
        req_valid      = 1'($urandom % 2);
        req_op         = 1'($urandom % 2);
        req_tag        = TW'($urandom);
        req_data       = rnd128();
        req_dirty      = 1'($urandom % 2);
        wb_ready       = 1'($urandom % 2);
        exp_req_ready  = 1'b0;
        exp_rsp_valid  = 1'b0;
        exp_rsp_hit    = 1'b0;
        exp_rsp_data   = '0;
        exp_rsp_dirty  = 1'b0;
        exp_wb_valid   = 1'b0;
        exp_wb_tag     = '0;
        exp_wb_data    = '0;
        exp_lru_update = '0;
        exp_add_cache  = 1'b0;
        chk_en         = 1'b1;
    endtask

    task automatic idle_cycle();
        begin_cycle();
        req_valid     = 1'b0;
        exp_req_ready = 1'b1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            reset = 1'b1;
            m_reset();
        end
        begin_cycle();
        reset         = 1'b0;
        req_valid     = 1'b0;
        exp_req_ready = 1'b1;
    endtask

    task automatic do_lookup(input logic [TW-1:0] t);
        int h;
        begin_cycle();
        req_valid = 1'b1; req_op = 1'b0; req_tag = t;
        exp_req_ready = 1'b1;
        begin_cycle();
        h = m_find(t);
        last_hit = h;
        exp_rsp_valid = 1'b1;
        if (h >= 0) begin
            exp_rsp_hit   = 1'b1;
            exp_rsp_data  = m_data[h];
            exp_rsp_dirty = m_dirty[h];
`ifdef VC_SWAP_EN
            m_valid[h] = 1'b0;
            m_dirty[h] = 1'b0;
`else
            exp_lru_update = 8'h01 << h;
            touch(h);
`endif
        end
    endtask

    task automatic do_insert(input logic [TW-1:0] t, input logic [DW-1:0] d, input logic dty,
                             input int wbd, input bit rst_wb);
        int h, f, k;
        begin_cycle();
        req_valid = 1'b1; req_op = 1'b1; req_tag = t; req_data = d; req_dirty = dty;
        exp_req_ready = 1'b1;
        begin_cycle();
        h = m_find(t);
        f = m_free();
        if (h >= 0) begin
            last_idx = h;
            exp_lru_update = 8'h01 << h;
            m_data[h]  = d;
            m_dirty[h] = m_dirty[h] | dty;
            touch(h);
        end else if (f >= 0) begin
            last_idx = f;
            exp_lru_update = 8'h01 << f;
            m_put(f, t, d, dty);
            touch(f);
        end else begin
            k = order[0];
            last_idx = k;
            if (!m_dirty[k]) begin
                exp_add_cache = 1'b1;
                m_put(k, t, d, dty);
                touch(k);
            end else if (rst_wb) begin
                begin_cycle();
                wb_ready     = 1'b0;
                exp_wb_valid = 1'b1;
                exp_wb_tag   = m_tag[k];
                exp_wb_data  = m_data[k];
                begin_cycle();
                wb_ready = 1'b0;
                reset    = 1'b1;
                m_reset();
                begin_cycle();
                reset         = 1'b0;
                req_valid     = 1'b0;
                exp_req_ready = 1'b1;
                rst_wb_done   = 1'b1;
            end else begin
                for (int c = 0; c <= wbd; c++) begin
                    begin_cycle();
                    wb_ready     = (c == wbd);
                    exp_wb_valid = 1'b1;
                    exp_wb_tag   = m_tag[k];
                    exp_wb_data  = m_data[k];
                    if (c == wbd) begin
                        last_wb_tag   = m_tag[k];
                        exp_add_cache = 1'b1;
                        m_put(k, t, d, dty);
                        touch(k);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [TW-1:0] hit_tags [7];
        m_reset();
        do_reset(3);

        // Miss on empty cache, no tracker pulse.
        do_lookup(TW'(26'h1234));
        chk("t1_model_miss", DW'(last_hit + 1), DW'(0));

        // Fill empty cache in order.
        for (int i = 0; i < 8; i++) begin
            do_insert(TW'(26'h10 + i), rnd128(), 1'b0, 0, 1'b0);
            chk("t2_slot", DW'(last_idx), DW'(i));
        end
        idle_cycle();
        chk("t2_add_cnt", DW'(add_cnt), DW'(0));

        // Clean oldest victim (entry 0).
        do_insert(TW'(26'h20), rnd128(), 1'b0, 0, 1'b0);
        idle_cycle();
        chk("t3_victim", DW'(last_idx), DW'(0));
        chk("t3_tag0", DW'(m_tag[0]), DW'(26'h20));
        chk("t3_add_cnt", DW'(add_cnt), DW'(1));
        chk("t3_wbv_cnt", DW'(wbv_cnt), DW'(0));

        // Make entry 3 (tag 0x13) dirty and the oldest, then evict it with a slow writeback.
        do_insert(TW'(26'h13), rnd128(), 1'b1, 0, 1'b0);
        hit_tags = '{26'h11, 26'h12, 26'h14, 26'h15, 26'h16, 26'h17, 26'h20};
        for (int i = 0; i < 7; i++) do_insert(hit_tags[i], rnd128(), 1'b0, 0, 1'b0);
        chk("t4_oldest", DW'(order[0]), DW'(3));
        do_insert(TW'(26'h21), rnd128(), 1'b0, 4, 1'b0);
        idle_cycle();
        chk("t4_wb_tag", DW'(last_wb_tag), DW'(26'h13));
        chk("t4_tag3", DW'(m_tag[3]), DW'(26'h21));
        chk("t4_wbv_cnt", DW'(wbv_cnt), DW'(5));
        chk("t4_add_cnt", DW'(add_cnt), DW'(2));

        // Hit on 0x15 at entry 5.
        do_lookup(TW'(26'h15));
        chk("t5_hit_idx", DW'(last_hit), DW'(5));
`ifdef VC_SWAP_EN
        do_insert(TW'(26'h30), rnd128(), 1'b0, 0, 1'b0);
        chk("t5_slot", DW'(last_idx), DW'(5));
`endif
        idle_cycle();
        chk("t5_lru_pulse", DW'(obs_lru), DW'(8'h20));

        // Random traffic over a tag pool larger than the cache.
        for (int n = 0; n < 300; n++) begin
            for (int g = 0; g < int'($urandom_range(0, 1)); g++) idle_cycle();
            if ($urandom % 2)
                do_lookup(TW'(26'h40 + $urandom_range(0, 11)));
            else
                do_insert(TW'(26'h40 + $urandom_range(0, 11)), rnd128(), 1'($urandom % 2),
                          $urandom_range(0, 3), 1'b0);
        end

        // Fill with dirty blocks, then reset in the middle of a writeback.
        for (int i = 0; i < 8; i++)
            do_insert(TW'(26'h80 + i), rnd128(), 1'b1, $urandom_range(0, 2), 1'b0);
        do_insert(TW'(26'h90), rnd128(), 1'b1, 0, 1'b1);
        chk("t6_reset_path", DW'(rst_wb_done), DW'(1));
        do_lookup(TW'(26'h80));
        chk("t6_model_miss", DW'(last_hit + 1), DW'(0));
        do_lookup(TW'(26'h87));
        do_insert(TW'(26'h90), rnd128(), 1'b0, 0, 1'b0);
        chk("t6_slot0", DW'(last_idx), DW'(0));
        idle_cycle();
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
